// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//
// Round-robin arbiter that shares one single-port bank of flip-flop registers
// among NREQ requesters. Each requester presents one read or write through a
// level req / pulsed ack handshake. One access runs at a time through the
// sequence IDLE -> GRANT -> ACCESS -> DONE, so acks are at least 4 cycles apart.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst_n    asynchronous active-low reset (clears FSM, outputs, pointer, bank)
//   req_i    per-requester request level
//   we_i     per-requester op, 1 = write, 0 = read
//   addr_i   per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   wdata_i  per-requester write data, requester i at [i*WIDTH +: WIDTH]
//   gnt_o    registered one-hot grant, high during GRANT, ACCESS and DONE
//   ack_o    registered one-hot completion pulse, high during DONE only
//   rdata_o  registered read data, updated only by reads
//   busy_o   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dff_bank_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ*WIDTH-1:0]    wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          ack_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     busy_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;

    logic                bank_we;
    logic [WIDTH-1:0]    bank_rd [DEPTH];

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;

    // Round-robin search starting at ptr_q; the first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bank_we = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Requester inputs are sampled only here; later changes are ignored.
                we_d    = we_i[sel_q];
                addr_d  = addr_i[int'(sel_q)*ADDR_W +: ADDR_W];
                wdata_d = wdata_i[int'(sel_q)*WIDTH +: WIDTH];
                state_d = ACCESS;
            end
            ACCESS: begin
                if (we_q) begin
                    bank_we = 1'b1;
                end else begin
                    rdata_d = bank_rd[addr_q];
                end
                // Registered so the pulse lands in the DONE cycle.
                ack_d   = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                ptr_d   = (sel_q == IDX_W'(NREQ-1)) ? '0 : sel_q + 1'b1;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Register bank: one flip-flop word per address, all cleared by reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
            logic [WIDTH-1:0] cell_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cell_q <= '0;
                end else if (bank_we && (addr_q == ADDR_W'(gi))) begin
                    cell_q <= wdata_q;
                end
            end

            assign bank_rd[gi] = cell_q;
        end
    endgenerate

    assign gnt_o   = gnt_q;
    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != IDLE);

endmodule
